// File: rtl/riscv_pipe_pkg.sv
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared constants and types for the elastic pipeline registers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pipe_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } pipe_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module      : pipe_slot
// Description : Valid bit plus payload register with load, drop and clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_slot #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             drop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Clear wins over load; a drop only invalidates, the payload stays visible.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = RESET_VAL;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic valid/ready pipeline register, optional skid slot.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SKID      = 0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_valid;
    logic [WIDTH-1:0] w_main_data;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_main_load;
    logic             w_main_drop;
    logic [WIDTH-1:0] w_main_din;
    logic             w_skid_load;
    logic             w_skid_drop;
    pipe_state_e      w_state;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = w_main_valid && out_ready;

    always_comb begin
        w_state = EMPTY;
        if (w_skid_valid)      w_state = SKIDDED;
        else if (w_main_valid) w_state = FULL;
    end

    // Slot controls; flush is applied as a clear inside each slot and overrides these.
    always_comb begin
        w_main_load = 1'b0;
        w_main_drop = 1'b0;
        w_main_din  = in_data;
        w_skid_load = 1'b0;
        w_skid_drop = 1'b0;
        case (w_state)
            EMPTY: begin
                w_main_load = w_in_xfer;
            end
            FULL: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_load = 1'b1;
                end else if (w_in_xfer) begin
                    w_skid_load = 1'b1;
                end else if (w_out_xfer) begin
                    w_main_drop = 1'b1;
                end
            end
            SKIDDED: begin
                if (w_out_xfer) begin
                    w_main_load = 1'b1;
                    w_main_din  = w_skid_data;
                    w_skid_drop = 1'b1;
                end
            end
            default: begin
                w_main_load = 1'b0;
            end
        endcase
    end

    pipe_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_slot (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (w_main_load),
        .drop_i  (w_main_drop),
        .data_i  (w_main_din),
        .valid_o (w_main_valid),
        .data_o  (w_main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_skid_slot (
                .clk     (clk),
                .rst     (rst),
                .clear_i (flush),
                .load_i  (w_skid_load),
                .drop_i  (w_skid_drop),
                .data_i  (in_data),
                .valid_o (w_skid_valid),
                .data_o  (w_skid_data)
            );
            // Ready comes from a flop, so out_ready never reaches in_ready.
            assign in_ready = !w_skid_valid;
        end else begin : g_noskid
            logic w_unused_skid;
            assign w_skid_valid  = 1'b0;
            assign w_skid_data   = RESET_VAL;
            assign w_unused_skid = w_skid_load | w_skid_drop;
            assign in_ready      = !w_main_valid || out_ready;
        end
    endgenerate

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (SKID=0, SKID=1, CNT_W=2).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    logic clk;
    logic rst;
    logic rst1;

    // u0: SKID=0, u1: SKID=1, u2: two-bit stall counter
    logic        v0, r0, ov0, or0, fl0;
    logic [31:0] d0, od0;
    logic [15:0] sc0;
    logic        v1, r1, ov1, or1, fl1;
    logic [31:0] d1, od1;
    logic [15:0] sc1;
    logic        v2, r2, ov2, or2, fl2;
    logic [7:0]  d2, od2;
    logic [1:0]  sc2;

    int n_cmp;
    int n_bad;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vec[7];

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h13), .SKID(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(fl0), .stall_cnt(sc0));

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h13), .SKID(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1), .stall_cnt(sc1));

    pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'h00), .SKID(0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2), .stall_cnt(sc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle on u1 with scoreboard bookkeeping; returns at posedge+1.
    task automatic cyc1(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic xin, xout;
        v1 = iv; d1 = d; or1 = ordy; fl1 = fl;
        #1;
        xin  = iv && r1;
        xout = ov1 && ordy;
        if (xout) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb1_spurious: got %0h expected no output", od1);
            end else begin
                chk("sb1_data", {32'h0, od1}, {32'h0, q1.pop_front()});
            end
        end
        if (fl) q1.delete();
        else if (xin) q1.push_back(d);
        @(posedge clk); #1;
    endtask

    initial begin
        int exp2[6];
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; rst1 = 1'b1;
        v0 = 0; d0 = 0; or0 = 0; fl0 = 0;
        v1 = 0; d1 = 0; or1 = 0; fl1 = 0;
        v2 = 0; d2 = 0; or2 = 0; fl2 = 0;
        #1 rst = 1'b0; rst1 = 1'b0;
        #2;
        chk("rst0_ov",  {63'h0, ov0}, 64'h0);
        chk("rst0_od",  {32'h0, od0}, 64'h13);
        chk("rst0_rdy", {63'h0, r0},  64'h1);
        chk("rst0_sc",  {48'h0, sc0}, 64'h0);
        chk("rst1_ov",  {63'h0, ov1}, 64'h0);
        chk("rst1_od",  {32'h0, od1}, 64'h13);
        chk("rst1_rdy", {63'h0, r1},  64'h1);
        chk("rst1_sc",  {48'h0, sc1}, 64'h0);
        #9 rst = 1'b1; rst1 = 1'b1;
        @(posedge clk); #1;

        // u0 back-to-back stream 1..8 with out_ready held high
        begin
            int n_out;
            logic xin, xout;
            n_out = 0;
            for (int k = 0; k < 10; k++) begin
                v0 = (k < 8); d0 = k + 1; or0 = 1'b1;
                #1;
                xin  = v0 && r0;
                xout = ov0 && or0;
                chk("str_rdy", {63'h0, r0}, 64'h1);
                if (k == 1) chk("str_latency", {63'h0, ov0}, 64'h1);
                if (xout) begin
                    n_out++;
                    if (q0.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL sb0_spurious: got %0h expected no output", od0);
                    end else begin
                        chk("sb0_data", {32'h0, od0}, {32'h0, q0.pop_front()});
                    end
                end
                if (xin) q0.push_back(d0);
                @(posedge clk); #1;
            end
            chk("str_count", 64'(n_out), 64'd8);
            chk("str_q_empty", 64'(q0.size()), 64'd0);
        end

        // u0 table: back-pressure, drain, flush with input, flush with output
        vec[0] = '{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 1'b1, 32'h21};
        vec[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h21};
        vec[2] = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22};
        vec[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h22};
        vec[4] = '{1'b1, 32'h23, 1'b0, 1'b1, 1'b1, 1'b0, 32'h13};
        vec[5] = '{1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b1, 32'h24};
        vec[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h13};
        for (int i = 0; i < 7; i++) begin
            v0 = vec[i].iv; d0 = vec[i].d; or0 = vec[i].ordy; fl0 = vec[i].fl;
            #1;
            chk("tbl_rdy", {63'h0, r0}, {63'h0, vec[i].exp_rdy});
            @(posedge clk); #1;
            chk("tbl_ov", {63'h0, ov0}, {63'h0, vec[i].exp_ov});
            chk("tbl_od", {32'h0, od0}, {32'h0, vec[i].exp_od});
        end
        v0 = 0; or0 = 0; fl0 = 0;
        chk("tbl_stall", {48'h0, sc0}, 64'd1);

        // u1 skid: A accepted, B into skid, C blocked while stalled for 3 cycles
        cyc1(1'b1, 32'hA, 1'b1, 1'b0);
        chk("sk_ov_a",  {63'h0, ov1}, 64'h1);
        chk("sk_rdy1",  {63'h0, r1},  64'h1);
        cyc1(1'b1, 32'hB, 1'b0, 1'b0);
        chk("sk_rdy2",  {63'h0, r1},  64'h0);
        chk("sk_sc1",   {48'h0, sc1}, 64'd1);
        cyc1(1'b1, 32'hC, 1'b0, 1'b0);
        cyc1(1'b1, 32'hC, 1'b0, 1'b0);
        chk("sk_rdy4",  {63'h0, r1},  64'h0);
        chk("sk_sc3",   {48'h0, sc1}, 64'd3);
        chk("sk_od_a",  {32'h0, od1}, 64'hA);
        cyc1(1'b1, 32'hC, 1'b1, 1'b0);
        chk("sk_rdy5",  {63'h0, r1},  64'h1);
        chk("sk_od_b",  {32'h0, od1}, 64'hB);
        cyc1(1'b1, 32'hC, 1'b1, 1'b0);
        cyc1(1'b0, 32'h0, 1'b1, 1'b0);
        chk("sk_drained", {63'h0, ov1}, 64'h0);
        chk("sk_q_empty", 64'(q1.size()), 64'd0);
        chk("sk_sc_hold", {48'h0, sc1}, 64'd3);

        // u1 flush while SKIDDED with a simultaneous offer of 0xD
        cyc1(1'b1, 32'hE, 1'b1, 1'b0);
        cyc1(1'b1, 32'hF, 1'b0, 1'b0);
        chk("fl_skidded", {63'h0, r1}, 64'h0);
        cyc1(1'b1, 32'hD, 1'b0, 1'b1);
        chk("fl_ov",  {63'h0, ov1}, 64'h0);
        chk("fl_od",  {32'h0, od1}, 64'h13);
        chk("fl_rdy", {63'h0, r1},  64'h1);
        chk("fl_sc",  {48'h0, sc1}, 64'd5);
        cyc1(1'b0, 32'h0, 1'b1, 1'b0);
        cyc1(1'b0, 32'h0, 1'b1, 1'b0);
        chk("fl_no_d", {63'h0, ov1}, 64'h0);

        // u1 asynchronous reset while SKIDDED
        cyc1(1'b1, 32'h5A, 1'b0, 1'b0);
        cyc1(1'b1, 32'h5B, 1'b0, 1'b0);
        chk("ar_pre_ov",  {63'h0, ov1}, 64'h1);
        chk("ar_pre_rdy", {63'h0, r1},  64'h0);
        v1 = 0; d1 = 0; or1 = 0;
        rst1 = 1'b0;
        #1;
        chk("ar_ov",  {63'h0, ov1}, 64'h0);
        chk("ar_od",  {32'h0, od1}, 64'h13);
        chk("ar_rdy", {63'h0, r1},  64'h1);
        chk("ar_sc",  {48'h0, sc1}, 64'd0);
        q1.delete();
        #2 rst1 = 1'b1;
        @(posedge clk); #1;
        cyc1(1'b1, 32'h77, 1'b1, 1'b0);
        chk("ar_new_od", {32'h0, od1}, 64'h77);
        cyc1(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ar_q_empty", 64'(q1.size()), 64'd0);

        // u2 saturating stall counter
        exp2 = '{1, 2, 3, 3, 3, 3};
        v2 = 1'b1; d2 = 8'h5; or2 = 1'b0;
        @(posedge clk); #1;
        v2 = 1'b0;
        chk("sat_ov", {63'h0, ov2}, 64'h1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("sat_cnt", {62'h0, sc2}, 64'(exp2[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register that replaces the fixed per-stage register layers between fetch, decode, execute, memory and write-back. Each stage boundary becomes one instance carrying a packed payload of configurable width. Stall is expressed as valid/ready back-pressure, and flush inserts a bubble whose payload is a configurable reset value, for example a NOP encoding. An optional skid slot removes the combinational ready path between stages, and a saturating counter reports stall cycles for performance analysis.

## Interface
- WIDTH, 64, payload width in bits (≥1)
- RESET_VAL, '0, payload value loaded on reset and on flush (WIDTH bits)
- SKID, 0, 0 = single slot; 1 = main slot plus skid slot
- CNT_W, 16, stall counter width (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept a payload
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage holds a valid payload
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  held payload
- flush  in  1  synchronous kill of all held payloads
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- States: EMPTY (main slot invalid), FULL (main slot valid, skid slot invalid), SKIDDED (both slots valid; reachable only when SKID=1).
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - EMPTY→FULL on input transfer.
  - FULL stays FULL on simultaneous input and output transfers; the main slot loads in_data.
  - FULL→EMPTY on output transfer with no input transfer.
- SKID=1:
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
  - EMPTY→FULL on input transfer.
  - FULL→SKIDDED on input transfer without output transfer; in_data goes to the skid slot.
  - SKIDDED→FULL on output transfer; the skid slot moves to the main slot. No input transfer is possible in SKIDDED.
  - FULL stays FULL on simultaneous input and output transfers.
  - FULL→EMPTY on output transfer only.
- Flush has priority over every transfer:
  - Next state is EMPTY; both data slots load RESET_VAL.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle is still valid, because downstream samples it at that edge.
- out_data always shows the main slot; it shows RESET_VAL while EMPTY after reset or flush.
- Payload is never reordered, duplicated or dropped, except when dropped by flush.
- stall_cnt increments by 1 on each edge where out_valid=1 && out_ready=0, independent of flush. It saturates at 2^CNT_W−1 and is cleared only by reset.

## Timing
- Reset values (asserted asynchronously):
  - out_valid=0, out_data=RESET_VAL, stall_cnt=0.
  - in_ready=1, since both SKID=0 and SKID=1 reset to EMPTY.
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N, and can be consumed at edge N+1.
- Throughput is 1 payload per cycle while out_ready=1, for both SKID values.
- SKID=1: in_ready falls one cycle after the first blocked output cycle, and rises the cycle after the skid slot drains.
- Reset released mid-stream: the first edge after deassertion behaves as if the stage is EMPTY. Any payload held before reset is lost.

## Structure
- Shared package riscv_pipe_pkg:
  - RV_NOP constant (32'h0000_0013).
  - pipe_state_e enum {EMPTY, FULL, SKIDDED} for debug visibility.
- One sub-module, pipe_slot: a valid bit plus WIDTH-bit data register with load, clear-to-RESET_VAL and async reset. It is instantiated once, or twice when SKID=1.
- The stall counter lives inline in pipe_stage_reg.

## Test plan
- Reset with WIDTH=32, RESET_VAL=32'h13 → out_valid=0, out_data=32'h13, in_ready=1, stall_cnt=0.
- SKID=0, out_ready=1, stream 0x1..0x8 back-to-back → 0x1..0x8 out in order, one per cycle, first word 1 cycle after accept.
- SKID=1, accept 0xA, drop out_ready for 3 cycles while offering 0xB,0xC → 0xB held in skid, in_ready=0 from cycle 2, 0xC waits. stall_cnt=3; output is 0xA,0xB,0xC after release.
- Flush in the same cycle as in_valid with 0xD while state is SKIDDED → next cycle out_valid=0, out_data=RESET_VAL, 0xD never appears.
- CNT_W=2, hold out_valid=1/out_ready=0 for 6 cycles → stall_cnt reads 1,2,3,3,3,3.
- Assert rst mid-stream with SKID=1 while SKIDDED → outputs take reset values immediately, without waiting for a clock edge.
